// File: rtl/ddr3_arb_pkg.sv
// Shared encodings for the DDR3 app-port arbiter.
// ARB_STATS_EN (optional) also brings in the statistics counter width.
package ddr3_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_TURN = 2'd3
  } arb_state_t;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } arb_dir_t;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

`ifdef ARB_STATS_EN
  localparam int unsigned STAT_W = 32;
`endif

endpackage

// File: rtl/ddr3_wdf_credit.sv
// Write-data credit counter: counts completed write bursts handed to the
// memory controller that have not yet been matched by a write command.
module ddr3_wdf_credit
  import ddr3_arb_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_wdf_wren,
  input  logic                i_wdf_end,
  input  logic                i_mc_wdf_rdy,
  input  logic                i_cmd_acc,
  output logic                o_wdf_rdy,
  output logic                o_mc_wdf_wren,
  output logic                o_mc_wdf_end,
  output logic [CREDIT_W-1:0] o_credit
);

  localparam logic [CREDIT_W-1:0] CREDIT_ZERO = CREDIT_W'(0);
  localparam logic [CREDIT_W-1:0] CREDIT_ONE  = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] CREDIT_FULL = {CREDIT_W{1'b1}};

  logic [CREDIT_W-1:0] r_credit;
  logic                w_full;
  logic                w_beat_acc;
  logic                w_inc;
  logic                w_dec;

  // A full counter back-pressures the requester so the count can never wrap.
  assign w_full     = (r_credit == CREDIT_FULL);
  assign w_beat_acc = i_wdf_wren & i_mc_wdf_rdy & ~w_full;
  assign w_inc      = w_beat_acc & i_wdf_end;
  assign w_dec      = i_cmd_acc & (r_credit != CREDIT_ZERO);

  assign o_wdf_rdy     = i_mc_wdf_rdy & ~w_full;
  assign o_mc_wdf_wren = w_beat_acc;
  assign o_mc_wdf_end  = w_beat_acc & i_wdf_end;
  assign o_credit      = r_credit;

  // Credit register: end beats add, write commands subtract, both cancel.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_credit <= CREDIT_ZERO;
    end else if (w_inc && !w_dec) begin
      r_credit <= r_credit + CREDIT_ONE;
    end else if (w_dec && !w_inc) begin
      r_credit <= r_credit - CREDIT_ONE;
    end else begin
      r_credit <= r_credit;
    end
  end

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Arbitrates the DDR3 app command port between fill-write and fill-read in
// bounded runs with turnaround bubbles; define ARB_STATS_EN for statistics.
module ddr3_app_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_W      = 26,
  parameter int MAX_RUN     = 16,
  parameter int TURN_CYCLES = 2,
  parameter int CREDIT_W    = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                acq_enabled,
  input  logic                wr_app_en,
  input  logic [ADDR_W-1:0]   wr_app_addr,
  output logic                wr_app_rdy,
  input  logic                rd_app_en,
  input  logic [ADDR_W-1:0]   rd_app_addr,
  output logic                rd_app_rdy,
  input  logic                wr_wdf_wren,
  input  logic                wr_wdf_end,
  output logic                wr_wdf_rdy,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_wdf_rdy,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  input  logic                app_rdy,
  output logic [1:0]          arb_state,
  output logic [CREDIT_W-1:0] wr_credit,
  output logic [31:0]         stat_wr_cmds,
  output logic [31:0]         stat_rd_cmds,
  output logic [31:0]         stat_turns,
  input  logic                stats_clr
);

  localparam int RUN_W  = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [RUN_W-1:0]  RUN_ZERO  = RUN_W'(0);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(MAX_RUN - 1);
  localparam logic [TURN_W-1:0] TURN_ZERO = TURN_W'(0);
  localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

  arb_state_t         r_state;
  arb_state_t         r_target;
  arb_dir_t           r_last_dir;
  logic [RUN_W-1:0]   r_run_cnt;
  logic [TURN_W-1:0]  r_turn_cnt;

  logic               w_wr_ok;
  logic               w_rd_ok;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_run_last;
  logic               w_wr_exit;
  logic               w_rd_exit;

  assign w_wr_ok    = wr_app_en & (wr_credit != {CREDIT_W{1'b0}});
  assign w_rd_ok    = rd_app_en & ~acq_enabled;
  assign w_wr_acc   = (r_state == ST_WR) & w_wr_ok & app_rdy;
  assign w_rd_acc   = (r_state == ST_RD) & w_rd_ok & app_rdy;
  // Run counter saturates, so a late-arriving opposite request still ends the run.
  assign w_run_last = (r_run_cnt == RUN_LAST);
  assign w_wr_exit  = ~w_wr_ok | (w_wr_acc & w_run_last & w_rd_ok);
  assign w_rd_exit  = ~w_rd_ok | (w_rd_acc & w_run_last & w_wr_ok);
  assign arb_state  = r_state;

  ddr3_wdf_credit #(
    .CREDIT_W (CREDIT_W)
  ) u_wdf_credit (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_wdf_wren    (wr_wdf_wren),
    .i_wdf_end     (wr_wdf_end),
    .i_mc_wdf_rdy  (app_wdf_rdy),
    .i_cmd_acc     (w_wr_acc),
    .o_wdf_rdy     (wr_wdf_rdy),
    .o_mc_wdf_wren (app_wdf_wren),
    .o_mc_wdf_end  (app_wdf_end),
    .o_credit      (wr_credit)
  );

  // Command mux: the granted requester drives the port with no added latency.
  always_comb begin
    app_en     = 1'b0;
    app_cmd    = CMD_WR;
    app_addr   = {ADDR_W{1'b0}};
    wr_app_rdy = 1'b0;
    rd_app_rdy = 1'b0;
    case (r_state)
      ST_WR: begin
        app_en     = w_wr_ok;
        app_cmd    = CMD_WR;
        app_addr   = wr_app_addr;
        wr_app_rdy = w_wr_acc;
      end
      ST_RD: begin
        app_en     = w_rd_ok;
        app_cmd    = CMD_RD;
        app_addr   = rd_app_addr;
        rd_app_rdy = w_rd_acc;
      end
      default: begin
        app_en = 1'b0;
      end
    endcase
  end

  // Grant FSM: run length, turnaround bubble and direction history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_target   <= ST_IDLE;
      r_last_dir <= DIR_WR;
      r_run_cnt  <= RUN_ZERO;
      r_turn_cnt <= TURN_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_ok && w_rd_ok) begin
            r_state <= (r_last_dir == DIR_WR) ? ST_RD : ST_WR;
          end else if (w_wr_ok) begin
            r_state <= ST_WR;
          end else if (w_rd_ok) begin
            r_state <= ST_RD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (w_wr_exit) begin
            r_run_cnt  <= RUN_ZERO;
            r_last_dir <= DIR_WR;
            if (w_rd_ok) begin
              r_state  <= ST_TURN;
              r_target <= ST_RD;
            end else begin
              r_state  <= ST_IDLE;
            end
          end else if (w_wr_acc && !w_run_last) begin
            r_run_cnt <= r_run_cnt + RUN_ONE;
          end
        end
        ST_RD: begin
          if (w_rd_exit) begin
            r_run_cnt  <= RUN_ZERO;
            r_last_dir <= DIR_RD;
            if (w_wr_ok) begin
              r_state  <= ST_TURN;
              r_target <= ST_WR;
            end else begin
              r_state  <= ST_IDLE;
            end
          end else if (w_rd_acc && !w_run_last) begin
            r_run_cnt <= r_run_cnt + RUN_ONE;
          end
        end
        ST_TURN: begin
          // Target is committed; if its request vanished it exits next cycle.
          if (r_turn_cnt == TURN_LAST) begin
            r_turn_cnt <= TURN_ZERO;
            r_state    <= r_target;
          end else begin
            r_turn_cnt <= r_turn_cnt + TURN_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic              w_turn_entry;
  logic [STAT_W-1:0] r_stat_wr;
  logic [STAT_W-1:0] r_stat_rd;
  logic [STAT_W-1:0] r_stat_turns;

  assign w_turn_entry = ((r_state == ST_WR) & w_wr_exit & w_rd_ok) |
                        ((r_state == ST_RD) & w_rd_exit & w_wr_ok);

  // Wrapping statistics counters; a clear request overrides counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_wr    <= STAT_W'(0);
      r_stat_rd    <= STAT_W'(0);
      r_stat_turns <= STAT_W'(0);
    end else if (stats_clr) begin
      r_stat_wr    <= STAT_W'(0);
      r_stat_rd    <= STAT_W'(0);
      r_stat_turns <= STAT_W'(0);
    end else begin
      if (w_wr_acc) r_stat_wr <= r_stat_wr + STAT_W'(1);
      if (w_rd_acc) r_stat_rd <= r_stat_rd + STAT_W'(1);
      if (w_turn_entry) r_stat_turns <= r_stat_turns + STAT_W'(1);
    end
  end

  assign stat_wr_cmds = r_stat_wr;
  assign stat_rd_cmds = r_stat_rd;
  assign stat_turns   = r_stat_turns;
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr;
  assign stat_wr_cmds = 32'd0;
  assign stat_rd_cmds = 32'd0;
  assign stat_turns   = 32'd0;
`endif

endmodule
